// File: rtl/fetch_pc_select.sv
// Fetch-stage PC selection: picks the address fetched this cycle and registers the
// predicted next PC, waiting out unresolved rets and parking on halts.
module fetch_pc_select #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        F_stall,
    input  logic [3:0]  f_icode,
    input  logic        f_imem_error,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic [3:0]  M_icode,
    input  logic        M_cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    output logic [63:0] f_pc,
    output logic [63:0] F_predPC,
    output logic        ret_stall,
    output logic        fetch_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_RET_WAIT = 2'd1,
        S_HALTED   = 2'd2
    } state_t;

    localparam logic [3:0] IC_HALT = 4'h0;
    localparam logic [3:0] IC_JXX  = 4'h7;
    localparam logic [3:0] IC_CALL = 4'h8;
    localparam logic [3:0] IC_RET  = 4'h9;

    state_t      r_state;
    logic [63:0] r_pred_pc;

    logic        w_mispredict;
    logic        w_wret;
    logic        w_correct;
    logic [63:0] w_pred;
    state_t      w_fetch_state;

    assign w_mispredict = (M_icode == IC_JXX) && !M_cnd;
    assign w_wret       = (W_icode == IC_RET);
    assign w_correct    = w_mispredict || w_wret;

    always_comb begin
        if (w_mispredict) begin
            f_pc = M_valA;
        end else if (w_wret) begin
            f_pc = W_valM;
        end else begin
            f_pc = r_pred_pc;
        end
    end

    assign w_pred = ((f_icode == IC_JXX) || (f_icode == IC_CALL)) ? f_valC : f_valP;

    // State implied by the instruction just fetched; shared by RUN and by corrections.
    always_comb begin
        if (f_imem_error || (f_icode == IC_HALT)) begin
            w_fetch_state = S_HALTED;
        end else if (f_icode == IC_RET) begin
            w_fetch_state = S_RET_WAIT;
        end else begin
            w_fetch_state = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_pc <= RESET_PC;
            r_state   <= S_RUN;
        end else if (w_correct) begin
            r_pred_pc <= w_pred;
            r_state   <= w_fetch_state;
        end else if (!F_stall && (r_state == S_RUN)) begin
            r_pred_pc <= w_pred;
            r_state   <= w_fetch_state;
        end
    end

    assign F_predPC    = r_pred_pc;
    assign fetch_valid = (r_state == S_RUN) || w_correct;
    assign ret_stall   = (r_state == S_RET_WAIT) && !w_correct;
    assign halted      = (r_state == S_HALTED);

endmodule

// File: doc/fetch_pc_select.md
FETCH_PC_SELECT -- requirements
Module: fetch_pc_select

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, giving the F_predPC value after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port F_stall, input, 1, hold request from the hazard unit.
REQ-005 SHALL have port f_icode, input, 4, icode of the instruction fetched at f_pc.
REQ-006 SHALL have port f_imem_error, input, 1, the fetch at f_pc faulted.
REQ-007 SHALL have ports f_valC and f_valP, input, 64 each, constant and fall-through address of the fetched instruction.
REQ-008 SHALL have ports M_icode (input, 4) and M_cnd (input, 1), the memory-stage icode and condition.
REQ-009 SHALL have port M_valA, input, 64, fall-through address carried by the memory-stage Jxx.
REQ-010 SHALL have ports W_icode (input, 4) and W_valM (input, 64), the write-back icode and loaded return address.
REQ-011 SHALL have port f_pc, output, 64, the address fetched this cycle (combinational).
REQ-012 SHALL have port F_predPC, output, 64, the registered predicted PC.
REQ-013 SHALL have port ret_stall, output, 1, asserted while fetch waits for a ret to resolve.
REQ-014 SHALL have port fetch_valid, output, 1, meaning the instruction at f_pc is to enter decode.
REQ-015 SHALL have port halted, output, 1, asserted while in state HALTED.

Function
REQ-016 SHALL use icode encodings halt=0, Jxx=7, call=8, ret=9; all other icodes are "sequential".
REQ-017 SHALL define mispredict = (M_icode==7 && M_cnd==0) and wret = (W_icode==9).
REQ-018 SHALL drive f_pc = M_valA if mispredict, else W_valM if wret, else F_predPC.
REQ-019 SHALL compute pred = f_valC for icode 7 or 8, else f_valP; no 64-bit wrap check, values pass unchanged.
REQ-020 SHALL implement states RUN, RET_WAIT, HALTED, held in a state register.
REQ-021 Transition priority SHALL be: rst > mispredict > wret > F_stall > state-local rules.
REQ-022 On mispredict, from any state: F_predPC <= pred; next state from the fetched icode per REQ-024, else RUN. This overrides F_stall, and a speculative halt or ret is squashed.
REQ-023 On wret without mispredict, from any state: F_predPC <= pred; next state per REQ-024, else RUN.
REQ-024 In RUN, without correction or F_stall: if f_imem_error or f_icode==0, go HALTED; if f_icode==9, go RET_WAIT; else stay RUN. In all three cases F_predPC <= pred.
REQ-025 In RET_WAIT without correction: hold F_predPC and state; ret_stall=1.
REQ-026 In HALTED without correction: hold F_predPC and state indefinitely.
REQ-027 F_stall without correction SHALL hold F_predPC and state unchanged in every state.
REQ-028 fetch_valid SHALL be 1 in RUN; 1 when mispredict or wret; else 0 in RET_WAIT and HALTED.
REQ-029 ret_stall SHALL be 1 only in RET_WAIT with neither mispredict nor wret.
REQ-030 halted SHALL equal (state==HALTED), registered, with no combinational override.
REQ-031 Latency: a correction affects f_pc in the same cycle and F_predPC at the next edge.

Reset
REQ-032 On rst sampled high: F_predPC <= RESET_PC and state <= RUN; this applies mid-RET_WAIT or mid-HALTED and takes priority over every input.
REQ-033 The cycle after reset, outputs SHALL be f_pc = RESET_PC (absent corrections), ret_stall=0, halted=0, fetch_valid=1.

Verification
REQ-034 Sequential fetch: reset, then f_icode=6, f_valP=0x2 -> next cycle F_predPC=0x2 and fetch_valid=1.
REQ-035 Taken prediction: f_icode=7, f_valC=0x40 -> F_predPC=0x40. Then M_icode=7, M_cnd=0, M_valA=0x9 -> f_pc=0x9 the same cycle.
REQ-036 Ret: f_icode=9 in RUN -> RET_WAIT with ret_stall=1 and fetch_valid=0 for 3 cycles. Then W_icode=9, W_valM=0x100 -> f_pc=0x100, fetch_valid=1, next state RUN.
REQ-037 Speculative halt squash: f_icode=0 -> halted=1. Next cycle mispredict with M_valA=0x20, f_icode=6, f_valP=0x22 -> F_predPC=0x22, halted=0.
REQ-038 Stall and priority: F_stall=1 holds F_predPC for 4 cycles. F_stall=1 with mispredict -> the correction is applied. rst=1 in HALTED -> F_predPC=RESET_PC, state RUN.
